// File: rtl/wishbone_counter_reg.sv
// Free-running 32-bit counter with Wishbone and SPI-side write ports; both ports read it back.
// Optional WBT_ADDR_MATCH_EN: writes apply only on address match (WB: BASE_ADDR, SPI: 0).

module wbc_byte_lane #(
  parameter int VEC_W = 8
) (
  input  logic             spi_we,
  input  logic             wb_wr,
  input  logic             sel,
  input  logic [VEC_W-1:0] spi_byte,
  input  logic [VEC_W-1:0] wb_byte,
  input  logic [VEC_W-1:0] inc_byte,
  output logic [VEC_W-1:0] nxt_byte
);
  always_comb begin
    nxt_byte = inc_byte;
    if (spi_we)            nxt_byte = spi_byte;
    else if (wb_wr && sel) nxt_byte = wb_byte;
  end
endmodule

module wishbone_counter_reg #(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  input  logic [31:0] wb_adr_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  input  logic        spi_we_i,
  input  logic [31:0] spi_data_i,
  input  logic [31:0] spi_addr_i,
  output logic [31:0] spi_data_o
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  logic [NUM_LANES-1:0][VEC_W-1:0] count, count_inc, count_nxt, spi_lanes, wb_lanes;
  logic wb_hit, spi_hit, wb_wr, spi_wr;

`ifdef WBT_ADDR_MATCH_EN
  assign wb_hit  = (wb_adr_i == BASE_ADDR);
  assign spi_hit = (spi_addr_i == 32'h0);
`else
  // Addresses are don't-care in the default build.
  logic unused_addr;
  assign unused_addr = ^{wb_adr_i, spi_addr_i, BASE_ADDR};
  assign wb_hit      = 1'b1;
  assign spi_hit     = 1'b1;
`endif

  assign wb_wr     = wb_cyc_i & wb_stb_i & wb_we_i & wb_hit;
  assign spi_wr    = spi_we_i & spi_hit;
  assign count_inc = count + 32'd1;
  assign spi_lanes = spi_data_i;
  assign wb_lanes  = wb_dat_i;

  // Unselected bytes take the incremented value, so carries still propagate.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    wbc_byte_lane #(.VEC_W(VEC_W)) u_lane (
      .spi_we   (spi_wr),
      .wb_wr    (wb_wr),
      .sel      (wb_sel_i[l]),
      .spi_byte (spi_lanes[l]),
      .wb_byte  (wb_lanes[l]),
      .inc_byte (count_inc[l]),
      .nxt_byte (count_nxt[l])
    );
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      count    <= RESET_VALUE;
      wb_ack_o <= 1'b0;
    end else begin
      count    <= count_nxt;
      wb_ack_o <= wb_cyc_i & wb_stb_i;
    end
  end

  assign wb_dat_o   = count;
  assign spi_data_o = count;
endmodule

// File: tb/tb_wishbone_counter_reg.sv
// Scoreboard bench for wishbone_counter_reg: driver pushes model expectations, monitor compares at negedge.
module tb_wishbone_counter_reg;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = 4'h0;
  logic [31:0] wb_dat_i = '0, wb_adr_i = '0;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic        spi_we_i = 1'b0;
  logic [31:0] spi_data_i = '0, spi_addr_i = '0;
  logic [31:0] spi_data_o;

  wishbone_counter_reg #(.RESET_VALUE(RV)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i), .wb_adr_i(wb_adr_i),
    .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o), .spi_we_i(spi_we_i), .spi_data_i(spi_data_i),
    .spi_addr_i(spi_addr_i), .spi_data_o(spi_data_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {logic [31:0] cnt; logic ack;} exp_t;
  exp_t        q[$];
  int          checks = 0, errors = 0;
  logic [31:0] m_cnt = RV;
  logic        m_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the next-count rule stated at the value level.
  task automatic model_edge();
    logic [31:0] inc;
    inc = m_cnt + 32'd1;
    if (!wb_rst_i) begin
      m_cnt = RV; m_ack = 1'b0;
    end else begin
      if (spi_we_i) m_cnt = spi_data_i;
      else if (wb_cyc_i && wb_stb_i && wb_we_i) begin
        for (int b = 0; b < 4; b++)
          m_cnt[8*b +: 8] = wb_sel_i[b] ? wb_dat_i[8*b +: 8] : inc[8*b +: 8];
      end else m_cnt = inc;
      m_ack = wb_cyc_i & wb_stb_i;
    end
  endtask

  task automatic step();
    exp_t e;
    model_edge();
    e.cnt = m_cnt; e.ack = m_ack;
    @(posedge wb_clk_i);
    q.push_back(e);
    @(negedge wb_clk_i);
    #1;
  endtask

  task automatic wb(input logic c, input logic s, input logic w, input logic [3:0] sel, input logic [31:0] d);
    wb_cyc_i = c; wb_stb_i = s; wb_we_i = w; wb_sel_i = sel; wb_dat_i = d;
  endtask

  always @(negedge wb_clk_i) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("wb_dat_o", wb_dat_o, e.cnt);
      chk("spi_data_o", spi_data_o, e.cnt);
      chk("wb_ack_o", {31'd0, wb_ack_o}, {31'd0, e.ack});
    end
  end

  initial begin
    repeat (2) step();
    wb_rst_i = 1'b1;
    step();
    chk("after_reset_count", wb_dat_o, 32'h1);
    wb(1, 1, 1, 4'hF, 32'hDEADBEEF); step();
    chk("full_write", wb_dat_o, 32'hDEADBEEF);
    wb(0, 0, 0, 4'h0, 32'h0); step();
    chk("post_write_inc", wb_dat_o, 32'hDEADBEF0);
    wb(1, 0, 1, 4'hF, 32'h12345678); step();
    chk("no_stb", wb_dat_o, 32'hDEADBEF1);
    wb(1, 1, 0, 4'hF, 32'h12345678); step();
    chk("read_cycle", wb_dat_o, 32'hDEADBEF2);
    wb(0, 1, 1, 4'hF, 32'h12345678); step();
    chk("no_cyc", wb_dat_o, 32'hDEADBEF3);
    wb(1, 1, 1, 4'hA, 32'hCAFEB0BA); step();
    chk("partial_write", wb_dat_o, 32'hCAADB0F4);
    wb(0, 0, 0, 4'h0, 32'h0);
    spi_we_i = 1'b1; spi_data_i = 32'h8BADF00D;
    step(); step();
    chk("spi_hold", spi_data_o, 32'h8BADF00D);
    spi_we_i = 1'b0; step();
    chk("spi_release", spi_data_o, 32'h8BADF00E);
    spi_we_i = 1'b1; wb(1, 1, 1, 4'hF, 32'hDEADBEEF);
    step(); step();
    chk("spi_priority", wb_dat_o, 32'h8BADF00D);
    chk("spi_priority_ack", {31'd0, wb_ack_o}, 32'h1);
    wb(0, 0, 0, 4'h0, 32'h0);
    spi_data_i = 32'hFFFFFFFF; step();
    spi_we_i = 1'b0; step();
    chk("wrap", wb_dat_o, 32'h0);

    for (int i = 0; i < 400; i++) begin
      wb_rst_i = ($urandom_range(0, 59) != 0);
      spi_we_i = ($urandom_range(0, 7) == 0);
      spi_data_i = $urandom_range(0, 3) == 0 ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom;
      spi_addr_i = $urandom;
      wb_adr_i = $urandom;
      wb(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), $urandom);
      step();
    end

    // Asynchronous reset in the middle of an acked write.
    wb_rst_i = 1'b1; spi_we_i = 1'b0;
    wb(1, 1, 1, 4'hF, 32'h55AA55AA); step();
    chk("pre_async_ack", {31'd0, wb_ack_o}, 32'h1);
    #2 wb_rst_i = 1'b0;
    #1;
    chk("async_rst_count", wb_dat_o, RV);
    chk("async_rst_spi", spi_data_o, RV);
    chk("async_rst_ack", {31'd0, wb_ack_o}, 32'h0);
    m_cnt = RV; m_ack = 1'b0;
    wb(0, 0, 0, 4'h0, 32'h0);
    step();

    for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge wb_clk_i);
    #1;
    if (q.size() > 0) begin
      errors++; checks++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
